button_press_classifier: RTL and testbench

BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_press_classifier_edge_detector.sv | 21 ++
 rtl/button_press_classifier.sv | 122 ++++++++++++
 tb/tb_button_press_classifier.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state type and default timing constants for the button classifier
package button_pkg;

  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned DCLICK_CYCLES_DEF = 12_500_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 5_000_000;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    WAIT_SECOND    = 3'd2,
    SECOND_PRESSED = 3'd3,
    LONG_HELD      = 3'd4
  } btn_state_t;

  // Largest of three timing parameters, used to size the shared cycle counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_press_classifier_edge_detector.sv
// rtl/button_press_classifier_edge_detector.sv - one-cycle rise/fall strobes of a synchronous level
module edge_detector (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic rise,
  output logic fall
);

  logic btn_q;

  // Previous-cycle button level; resets low so a held button reads as a fresh rise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) btn_q <= 1'b0;
    else          btn_q <= btn_i;
  end

  assign rise = btn_i & ~btn_q;
  assign fall = ~btn_i & btn_q;

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - single/double/long press classifier; BUTTON_PRESS_CLASSIFIER_AUTOREPEAT_EN enables long-press autorepeat
module button_press_classifier
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned DCLICK_CYCLES = DCLICK_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic press_o,
  output logic single_o,
  output logic double_o,
  output logic long_o,
  output logic busy_o
);

  // One spare bit above the largest timeout so no compare value can alias a wrapped count.
  localparam int unsigned CNT_W = $clog2(max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
`ifdef BUTTON_PRESS_CLASSIFIER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             rise;
  logic             fall;
  btn_state_t       state;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             single_d;
  logic             double_d;
  logic             long_d;

  edge_detector u_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .btn_i   (btn_i),
    .rise    (rise),
    .fall    (fall)
  );

  // Next-state and pulse decode; edges are tested before timeouts so they win ties.
  always_comb begin
    state_d  = state;
    cnt_clr  = 1'b0;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_d = PRESSED;
      end
      PRESSED: begin
        if (fall) begin
          state_d = WAIT_SECOND;
        end else if (cnt == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          state_d  = SECOND_PRESSED;
          double_d = 1'b1;
        end else if (cnt == DCLICK_LAST) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (fall) state_d = IDLE;
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
        end
`ifdef BUTTON_PRESS_CLASSIFIER_AUTOREPEAT_EN
        else if (btn_i && (cnt == REPEAT_LAST)) begin
          long_d  = 1'b1;
          cnt_clr = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and dwell counter; counter restarts on entry and saturates while parked.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if ((state_d != state) || cnt_clr) cnt <= '0;
      else if (cnt != CNT_MAX)           cnt <= cnt + 1'b1;
    end
  end

  // Registered outputs: every pulse lands the cycle after the condition that caused it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      press_o  <= 1'b0;
      single_o <= 1'b0;
      double_o <= 1'b0;
      long_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      press_o  <= rise;
      single_o <= single_d;
      double_o <= double_d;
      long_o   <= long_d;
      busy_o   <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - self-checking bench for button_press_classifier (honours BUTTON_PRESS_CLASSIFIER_AUTOREPEAT_EN)
module tb_button_press_classifier;

  localparam int L = 8;
  localparam int D = 4;
  localparam int R = 3;
  localparam int MAXN = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic press, single_p, dbl_p, long_p, busy;

  int checks = 0;
  int errors = 0;

  bit         seq [MAXN];
  int         len;
  logic [4:0] act [MAXN];
  logic [4:0] expv[MAXN];

  always #5 clk = ~clk;

  button_press_classifier #(
    .LONG_CYCLES   (L),
    .DCLICK_CYCLES (D),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .btn_i    (btn),
    .press_o  (press),
    .single_o (single_p),
    .double_o (dbl_p),
    .long_o   (long_p),
    .busy_o   (busy)
  );

  task automatic add(input bit v, input int n);
    for (int i = 0; i < n; i++) if (len < MAXN) begin seq[len] = v; len++; end
  endtask

  function automatic int first_idx(input bit v, input int from);
    for (int j = from; j < len; j++) if (seq[j] == v) return j;
    return len;
  endfunction

  task automatic set_exp(input int t, input int bitpos);
    if (t >= 0 && t < len) expv[t][bitpos] = 1'b1;
  endtask

  // Expected bits {press,single,double,long,busy}: episodes walked from rise/fall positions.
  task automatic build_model();
    int r, f, r2, f2, nx;
    for (int k = 0; k < len; k++) expv[k] = '0;
    for (int k = 0; k < len; k++)
      if (seq[k] && (k == 0 || !seq[k-1])) set_exp(k + 1, 4);
    nx = 0;
    while (nx < len) begin
      r = nx;
      while (r < len && !(seq[r] && (r == 0 || !seq[r-1]))) r++;
      if (r >= len) break;
      f = first_idx(1'b0, r + 1);
      if (f > r + L) begin
        set_exp(r + L + 1, 1);
`ifdef BUTTON_PRESS_CLASSIFIER_AUTOREPEAT_EN
        for (int c = r + L + R; c < f; c += R) set_exp(c + 1, 1);
`endif
        for (int t = r + 1; t <= f; t++) set_exp(t, 0);
        nx = f + 1;
      end else begin
        r2 = first_idx(1'b1, f + 1);
        if (r2 <= f + D) begin
          set_exp(r2 + 1, 2);
          f2 = first_idx(1'b0, r2 + 1);
          for (int t = r + 1; t <= f2; t++) set_exp(t, 0);
          nx = f2 + 1;
        end else begin
          set_exp(f + D + 1, 3);
          for (int t = r + 1; t <= f + D; t++) set_exp(t, 0);
          nx = f + D + 1;
        end
      end
    end
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drives seq[k] in cycle k and records the outputs visible in cycle k; releases reset at cycle 0.
  task automatic apply_seq();
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      act[k] = {press, single_p, dbl_p, long_p, busy};
      btn    = seq[k];
      rst_n  = 1'b1;
    end
  endtask

  task automatic test_reset();
    enter_reset();
    checks++;
    if ({press, single_p, dbl_p, long_p, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {press, single_p, dbl_p, long_p, busy}, 5'b0);
    end
  endtask

  task automatic test_single();
    int n_s, n_d, n_l, n_p;
    enter_reset();
    len = 0; add(1'b1, 3); add(1'b0, 12);
    build_model(); apply_seq();
    n_s = 0; n_d = 0; n_l = 0; n_p = 0;
    for (int k = 0; k < len; k++) begin
      checks++;
      if (act[k] !== expv[k]) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b exp=%b", k, act[k], expv[k]);
      end
      n_p += int'(act[k][4]); n_s += int'(act[k][3]); n_d += int'(act[k][2]); n_l += int'(act[k][1]);
    end
    checks++;
    if (n_p !== 1 || n_s !== 1 || n_d !== 0 || n_l !== 0) begin
      errors++;
      $display("FAIL single_counts got p%0d s%0d d%0d l%0d exp p1 s1 d0 l0", n_p, n_s, n_d, n_l);
    end
  endtask

  task automatic test_double();
    int n_s, n_d, n_p;
    enter_reset();
    len = 0; add(1'b1, 3); add(1'b0, 2); add(1'b1, 3); add(1'b0, 12);
    build_model(); apply_seq();
    n_s = 0; n_d = 0; n_p = 0;
    for (int k = 0; k < len; k++) begin
      checks++;
      if (act[k] !== expv[k]) begin
        errors++;
        $display("FAIL double cyc=%0d got=%b exp=%b", k, act[k], expv[k]);
      end
      n_p += int'(act[k][4]); n_s += int'(act[k][3]); n_d += int'(act[k][2]);
    end
    checks++;
    if (n_p !== 2 || n_s !== 0 || n_d !== 1 || act[6][2] !== 1'b1) begin
      errors++;
      $display("FAIL double_counts got p%0d s%0d d%0d at6=%b exp p2 s0 d1 at6=1", n_p, n_s, n_d, act[6][2]);
    end
  endtask

  task automatic test_long();
    int n_l, want;
`ifdef BUTTON_PRESS_CLASSIFIER_AUTOREPEAT_EN
    want = 4;
`else
    want = 1;
`endif
    enter_reset();
    len = 0; add(1'b1, 20); add(1'b0, 10);
    build_model(); apply_seq();
    n_l = 0;
    for (int k = 0; k < len; k++) begin
      checks++;
      if (act[k] !== expv[k]) begin
        errors++;
        $display("FAIL long cyc=%0d got=%b exp=%b", k, act[k], expv[k]);
      end
      n_l += int'(act[k][1]);
    end
    checks++;
    if (n_l !== want || act[9][1] !== 1'b1) begin
      errors++;
      $display("FAIL long_counts got n=%0d at9=%b exp n=%0d at9=1", n_l, act[9][1], want);
    end
  endtask

  task automatic test_fall_at_timeout();
    int n_s, n_l;
    enter_reset();
    len = 0; add(1'b1, 8); add(1'b0, 12);
    build_model(); apply_seq();
    n_s = 0; n_l = 0;
    for (int k = 0; k < len; k++) begin
      checks++;
      if (act[k] !== expv[k]) begin
        errors++;
        $display("FAIL fall_timeout cyc=%0d got=%b exp=%b", k, act[k], expv[k]);
      end
      n_s += int'(act[k][3]); n_l += int'(act[k][1]);
    end
    checks++;
    if (n_s !== 1 || n_l !== 0) begin
      errors++;
      $display("FAIL fall_timeout_counts got s%0d l%0d exp s1 l0", n_s, n_l);
    end
  endtask

  task automatic test_mid_reset();
    enter_reset();
    len = 0; add(1'b1, 3); add(1'b0, 2);
    apply_seq();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_busy_before got=%b exp=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({press, single_p, dbl_p, long_p, busy} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_async got=%b exp=%b", {press, single_p, dbl_p, long_p, busy}, 5'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({press, single_p, dbl_p, long_p, busy} !== 5'b0) begin
        errors++;
        $display("FAIL mid_reset_after cyc=%0d got=%b exp=%b", k, {press, single_p, dbl_p, long_p, busy}, 5'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    enter_reset();
    len = 0; add(1'b1, 3); add(1'b0, 2); add(1'b1, 2); add(1'b0, 12);
    build_model(); apply_seq();
    for (int k = 0; k < len; k++) begin
      checks++;
      if (act[k] !== expv[k]) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", k, act[k], expv[k]);
      end
    end
  endtask

  task automatic test_random();
    int errs_shown = 0;
    for (int it = 0; it < 12; it++) begin
      enter_reset();
      len = 0;
      for (int s = 0; s < 6; s++) begin
        add(1'b1, $urandom_range(1, 14));
        add(1'b0, $urandom_range(1, 7));
      end
      add(1'b0, D + 6);
      build_model(); apply_seq();
      for (int k = 0; k < len; k++) begin
        checks++;
        if (act[k] !== expv[k]) begin
          errors++;
          if (errs_shown < 20) begin
            errs_shown++;
            $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, k, act[k], expv[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_long();
    test_fall_at_timeout();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
